aes_fifo_block_bridge: RTL and testbench

//  Consumer of the host-to-CL 32-bit word FIFO (FIFO_Shanquan) and producer into the CL-to-host word FIFO.

---
 rtl/aes_bridge_pkg.sv | 28 ++
 rtl/aes_word_shifter.sv | 51 +++++
 rtl/aes_fifo_block_bridge.sv | 161 ++++++++++++++++
 tb/tb_aes_fifo_block_bridge.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_bridge_pkg.sv
// Shared definitions for the AES FIFO block bridge: default widths, FSM encoding
// and the word byte-reversal helper used when AES_BRIDGE_BYTE_SWAP_EN is defined.
package aes_bridge_pkg;

  localparam int AES_DATA_W  = 32;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORDS   = AES_BLOCK_W / AES_DATA_W;

  typedef enum logic [2:0] {
    ST_FILL     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAP   = 3'd2,
    ST_SEND     = 3'd3,
    ST_RESULT   = 3'd4,
    ST_DRAIN    = 3'd5
  } state_e;

  // Reverses byte order within one FIFO word (byte 0 becomes the top byte).
  function automatic logic [AES_DATA_W-1:0] byte_swap(input logic [AES_DATA_W-1:0] w);
    logic [AES_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < AES_DATA_W / 8; i++) begin
      r[i*8 +: 8] = w[AES_DATA_W-8-i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_word_shifter.sv
// Word-granular shift register with parallel load and a wrap-around word counter.
// Used once to pack FIFO words into a block and once to unpack a block into words.
module aes_word_shifter #(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int OUT_W   = BLOCK_W,
  parameter int CNT_W   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift,
  input  logic [DATA_W-1:0]  shift_in,
  output logic [OUT_W-1:0]   data_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               last_o
);

  localparam int WORDS = BLOCK_W / DATA_W;

  logic [BLOCK_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign last_o = (cnt_q == CNT_W'(WORDS - 1));
  assign cnt_o  = cnt_q;
  assign data_o = data_q[BLOCK_W-1 -: OUT_W];

  // Words enter at the bottom and leave from the top, so the first word ends up highest.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
    end else if (shift) begin
      data_d = {data_q[BLOCK_W-DATA_W-1:0], shift_in};
      cnt_d  = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_fifo_block_bridge.sv
// Bridges the host word FIFOs to the AES core: packs words into blocks, unpacks results.
// Define AES_BRIDGE_BYTE_SWAP_EN to byte-reverse each word on capture and on output.
module aes_fifo_block_bridge
  import aes_bridge_pkg::*;
#(
  parameter int DATA_W  = AES_DATA_W,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               data_empty,
  output logic               data_rd,
  input  logic [DATA_W-1:0]  data_din,
  input  logic               data_full,
  output logic               data_wr,
  output logic [DATA_W-1:0]  data_dout,
  output logic               core_in_valid,
  input  logic               core_in_ready,
  output logic [BLOCK_W-1:0] core_in_data,
  input  logic               core_out_valid,
  output logic               core_out_ready,
  input  logic [BLOCK_W-1:0] core_out_data,
  output logic [CNT_W-1:0]   blocks_in,
  output logic [CNT_W-1:0]   blocks_out,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int WORDS  = BLOCK_W / DATA_W;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // core_in_valid/core_in_data stay stable until then, and core_out_ready is only
  // offered while the bridge has room for a whole result block.

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   blocks_in_q, blocks_in_d;
  logic [CNT_W-1:0]   blocks_out_q, blocks_out_d;
  logic [WCNT_W-1:0]  in_cnt, out_cnt;
  logic               in_last, out_last;
  logic               in_shift, out_load, out_shift;
  logic [DATA_W-1:0]  in_word, out_word;
  logic [BLOCK_W-1:0] in_data;

`ifdef AES_BRIDGE_BYTE_SWAP_EN
  assign in_word   = byte_swap(data_din);
  assign data_dout = byte_swap(out_word);
`else
  assign in_word   = data_din;
  assign data_dout = out_word;
`endif

  aes_word_shifter #(
    .DATA_W (DATA_W),
    .BLOCK_W(BLOCK_W),
    .OUT_W  (BLOCK_W),
    .CNT_W  (WCNT_W)
  ) u_pack (
    .clock    (clock),
    .reset    (reset),
    .load     (1'b0),
    .load_data('0),
    .shift    (in_shift),
    .shift_in (in_word),
    .data_o   (in_data),
    .cnt_o    (in_cnt),
    .last_o   (in_last)
  );

  aes_word_shifter #(
    .DATA_W (DATA_W),
    .BLOCK_W(BLOCK_W),
    .OUT_W  (DATA_W),
    .CNT_W  (WCNT_W)
  ) u_unpack (
    .clock    (clock),
    .reset    (reset),
    .load     (out_load),
    .load_data(core_out_data),
    .shift    (out_shift),
    .shift_in ('0),
    .data_o   (out_word),
    .cnt_o    (out_cnt),
    .last_o   (out_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:     if (!data_empty) state_d = ST_RD_ISSUE;
      ST_RD_ISSUE: state_d = ST_RD_CAP;
      ST_RD_CAP:   state_d = in_last ? ST_SEND : ST_FILL;
      ST_SEND:     if (core_in_ready) state_d = ST_RESULT;
      ST_RESULT:   if (core_out_valid) state_d = ST_DRAIN;
      ST_DRAIN:    if (!data_full && out_last) state_d = ST_FILL;
      default:     state_d = ST_FILL;
    endcase
  end

  // Read and write strobes come from disjoint states, so they can never overlap.
  always_comb begin
    data_rd        = 1'b0;
    data_wr        = 1'b0;
    core_in_valid  = 1'b0;
    core_out_ready = 1'b0;
    in_shift       = 1'b0;
    out_load       = 1'b0;
    out_shift      = 1'b0;
    case (state_q)
      ST_RD_ISSUE: data_rd = 1'b1;
      ST_RD_CAP:   in_shift = 1'b1;
      ST_SEND:     core_in_valid = 1'b1;
      ST_RESULT: begin
        core_out_ready = 1'b1;
        out_load       = core_out_valid;
      end
      ST_DRAIN: begin
        data_wr   = !data_full;
        out_shift = !data_full;
      end
      default: ;
    endcase
  end

  always_comb begin
    blocks_in_d  = blocks_in_q;
    blocks_out_d = blocks_out_q;
    if (state_q == ST_SEND && core_in_ready) begin
      blocks_in_d = blocks_in_q + 1'b1;
    end
    if (state_q == ST_DRAIN && !data_full && out_last) begin
      blocks_out_d = blocks_out_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blocks_in_q  <= '0;
      blocks_out_q <= '0;
    end else begin
      blocks_in_q  <= blocks_in_d;
      blocks_out_q <= blocks_out_d;
    end
  end

  assign core_in_data = in_data;
  assign blocks_in    = blocks_in_q;
  assign blocks_out   = blocks_out_q;
  assign busy         = (state_q != ST_FILL) || (in_cnt != '0) || (out_cnt != '0);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_aes_fifo_block_bridge.sv
// Self-checking bench for aes_fifo_block_bridge with FIFO models and an identity AES core.
// Honours AES_BRIDGE_BYTE_SWAP_EN when computing expected blocks.
module tb_aes_fifo_block_bridge;

  localparam int DW = 32;
  localparam int BW = 128;
  localparam int CW = 16;
  localparam int NW = BW / DW;
  localparam int BUDGET = 400;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          data_empty = 1'b1;
  logic          data_rd;
  logic [DW-1:0] data_din = '0;
  logic          data_full = 1'b0;
  logic          data_wr;
  logic [DW-1:0] data_dout;
  logic          core_in_valid;
  logic          core_in_ready = 1'b1;
  logic [BW-1:0] core_in_data;
  logic          core_out_valid = 1'b0;
  logic          core_out_ready;
  logic [BW-1:0] core_out_data = '0;
  logic [CW-1:0] blocks_in;
  logic [CW-1:0] blocks_out;
  logic          busy;
  logic [2:0]    dbg_state;

  logic [DW-1:0] in_fifo[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [BW-1:0] exp_blk_q[$];
  logic [BW-1:0] blk_q[$];
  int rd_pulses = 0;
  int overlap_cnt = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;
  int exp_blocks = 0;

  aes_fifo_block_bridge #(.DATA_W(DW), .BLOCK_W(BW), .CNT_W(CW)) dut (
    .clock         (clock),
    .reset         (reset),
    .data_empty    (data_empty),
    .data_rd       (data_rd),
    .data_din      (data_din),
    .data_full     (data_full),
    .data_wr       (data_wr),
    .data_dout     (data_dout),
    .core_in_valid (core_in_valid),
    .core_in_ready (core_in_ready),
    .core_in_data  (core_in_data),
    .core_out_valid(core_out_valid),
    .core_out_ready(core_out_ready),
    .core_out_data (core_out_data),
    .blocks_in     (blocks_in),
    .blocks_out    (blocks_out),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- environment models ----------------
  always @(posedge clock) begin : in_fifo_model
    int n;
    n = in_fifo.size();
    if (data_rd && n > 0) begin
      data_din <= in_fifo.pop_front();
      n--;
    end
    data_empty <= (n == 0);
  end

  always @(posedge clock or posedge reset) begin : identity_core
    if (reset) begin
      core_out_valid <= 1'b0;
    end else if (core_in_valid && core_in_ready && !core_out_valid) begin
      blk_q.push_back(core_in_data);
      core_out_data  <= core_in_data;
      core_out_valid <= 1'b1;
    end else if (core_out_valid && core_out_ready) begin
      core_out_valid <= 1'b0;
    end
  end

  always @(negedge clock) begin : out_monitor
    if (data_wr) got_q.push_back(data_dout);
    if (data_rd) rd_pulses++;
    if (data_rd && data_wr) overlap_cnt++;
  end

  // ---------------- expectation helpers ----------------
  function automatic logic [DW-1:0] swap_word(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = {<<8{w}};
    return r;
  endfunction

  function automatic logic [BW-1:0] model_block(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
`ifdef AES_BRIDGE_BYTE_SWAP_EN
    for (int i = 0; i < NW; i++) r[i*DW +: DW] = swap_word(b[i*DW +: DW]);
`endif
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_words(input logic [BW-1:0] blk, input int first, input int n);
    for (int i = first; i < first + n; i++) in_fifo.push_back(blk[BW-1-i*DW -: DW]);
  endtask

  task automatic expect_block(input logic [BW-1:0] blk);
    exp_blk_q.push_back(model_block(blk));
    for (int i = 0; i < NW; i++) exp_q.push_back(blk[BW-1-i*DW -: DW]);
    exp_blocks++;
  endtask

  task automatic wait_io(input int nblk, input int nwords, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clock); #1;
      if (blk_q.size() >= nblk && got_q.size() >= nwords) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clock); #1;
      if (!busy && data_empty) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_cnt++; if (dbg_state !== 3'd0) $display("FAIL rst_state: got %0d exp 0", dbg_state); else pass_cnt++;
    chk_cnt++; if ({data_rd, data_wr, core_in_valid, core_out_ready} !== 4'b0) $display("FAIL rst_strobes: got %b exp 0000", {data_rd, data_wr, core_in_valid, core_out_ready}); else pass_cnt++;
    chk_cnt++; if (data_dout !== '0) $display("FAIL rst_dout: got %h exp 0", data_dout); else pass_cnt++;
    chk_cnt++; if (core_in_data !== '0) $display("FAIL rst_core_in_data: got %h exp 0", core_in_data); else pass_cnt++;
    chk_cnt++; if ({blocks_in, blocks_out} !== '0) $display("FAIL rst_counters: got %h/%h exp 0/0", blocks_in, blocks_out); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_block();
    logic [BW-1:0] blk, g_b, e_b;
    logic [DW-1:0] g_w, e_w;
    int rd0;
    bit ok;
    blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    rd0 = rd_pulses;
    push_words(blk, 0, NW);
    expect_block(blk);
    wait_io(1, NW, ok);
    chk_cnt++; if (!ok) $display("FAIL single_timeout: got %0d blocks %0d words exp 1/4", blk_q.size(), got_q.size()); else pass_cnt++;
    g_b = (blk_q.size() > 0) ? blk_q.pop_front() : 'x;
    e_b = exp_blk_q.pop_front();
    chk_cnt++; if (g_b !== e_b) $display("FAIL single_block: got %h exp %h", g_b, e_b); else pass_cnt++;
    for (int i = 0; i < NW; i++) begin
      g_w = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      e_w = exp_q.pop_front();
      chk_cnt++; if (g_w !== e_w) $display("FAIL single_word%0d: got %h exp %h", i, g_w, e_w); else pass_cnt++;
    end
    wait_idle(ok);
    chk_cnt++; if (blocks_in !== CW'(exp_blocks) || blocks_out !== CW'(exp_blocks)) $display("FAIL single_counters: got %0d/%0d exp %0d", blocks_in, blocks_out, exp_blocks); else pass_cnt++;
    chk_cnt++; if (rd_pulses - rd0 != NW) $display("FAIL single_rd_pulses: got %0d exp %0d", rd_pulses - rd0, NW); else pass_cnt++;
  endtask

  task automatic test_partial_block();
    logic [BW-1:0] blk, g_b, e_b;
    logic [DW-1:0] g_w, e_w;
    int rd0, civ_seen;
    bit ok;
    blk = rand_block();
    rd0 = rd_pulses;
    civ_seen = 0;
    push_words(blk, 0, NW - 1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (core_in_valid) civ_seen++;
    end
    #1;
    chk_cnt++; if (rd_pulses - rd0 != NW - 1) $display("FAIL partial_rd_pulses: got %0d exp %0d", rd_pulses - rd0, NW - 1); else pass_cnt++;
    chk_cnt++; if (civ_seen != 0) $display("FAIL partial_core_in_valid: got %0d cycles exp 0", civ_seen); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL partial_busy: got %b exp 1", busy); else pass_cnt++;
    push_words(blk, NW - 1, 1);
    expect_block(blk);
    wait_io(1, NW, ok);
    chk_cnt++; if (!ok) $display("FAIL partial_timeout: got %0d blocks %0d words exp 1/4", blk_q.size(), got_q.size()); else pass_cnt++;
    g_b = (blk_q.size() > 0) ? blk_q.pop_front() : 'x;
    e_b = exp_blk_q.pop_front();
    chk_cnt++; if (g_b !== e_b) $display("FAIL partial_block: got %h exp %h", g_b, e_b); else pass_cnt++;
    for (int i = 0; i < NW; i++) begin
      g_w = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      e_w = exp_q.pop_front();
      chk_cnt++; if (g_w !== e_w) $display("FAIL partial_word%0d: got %h exp %h", i, g_w, e_w); else pass_cnt++;
    end
    wait_idle(ok);
    chk_cnt++; if (blocks_out !== CW'(exp_blocks)) $display("FAIL partial_blocks_out: got %0d exp %0d", blocks_out, exp_blocks); else pass_cnt++;
  endtask

  task automatic test_in_backpressure();
    logic [BW-1:0] blk, g_b, e_b;
    logic [DW-1:0] g_w, e_w;
    int rd0, held;
    bit ok;
    blk = rand_block();
    @(posedge clock); #1;
    core_in_ready = 1'b0;
    push_words(blk, 0, NW);
    expect_block(blk);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clock); #1;
      if (core_in_valid) begin ok = 1'b1; break; end
    end
    chk_cnt++; if (!ok) $display("FAIL stall_valid_timeout: got 0 exp 1"); else pass_cnt++;
    rd0 = rd_pulses;
    held = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); #1;
      if (core_in_valid === 1'b1 && core_in_data === exp_blk_q[0]) held++;
    end
    chk_cnt++; if (held != 10) $display("FAIL stall_hold: got %0d cycles exp 10", held); else pass_cnt++;
    chk_cnt++; if (rd_pulses != rd0) $display("FAIL stall_rd_pulses: got %0d exp 0", rd_pulses - rd0); else pass_cnt++;
    chk_cnt++; if (blocks_in !== CW'(exp_blocks - 1)) $display("FAIL stall_blocks_in: got %0d exp %0d", blocks_in, exp_blocks - 1); else pass_cnt++;
    @(posedge clock); #1;
    core_in_ready = 1'b1;
    wait_io(1, NW, ok);
    g_b = (blk_q.size() > 0) ? blk_q.pop_front() : 'x;
    e_b = exp_blk_q.pop_front();
    chk_cnt++; if (g_b !== e_b) $display("FAIL stall_block: got %h exp %h", g_b, e_b); else pass_cnt++;
    for (int i = 0; i < NW; i++) begin
      g_w = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      e_w = exp_q.pop_front();
      chk_cnt++; if (g_w !== e_w) $display("FAIL stall_word%0d: got %h exp %h", i, g_w, e_w); else pass_cnt++;
    end
    wait_idle(ok);
  endtask

  task automatic test_out_backpressure();
    logic [BW-1:0] blk, g_b, e_b;
    logic [DW-1:0] g_w, e_w;
    int wr_seen;
    bit ok;
    blk = rand_block();
    push_words(blk, 0, NW);
    expect_block(blk);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clock); #1;
      if (got_q.size() >= 2) begin ok = 1'b1; break; end
    end
    chk_cnt++; if (!ok) $display("FAIL full_two_writes_timeout: got %0d exp 2", got_q.size()); else pass_cnt++;
    @(posedge clock); #1;
    data_full = 1'b1;
    wr_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (data_wr !== 1'b0) wr_seen++;
    end
    chk_cnt++; if (wr_seen != 0) $display("FAIL full_wr_blocked: got %0d writes exp 0", wr_seen); else pass_cnt++;
    @(posedge clock); #1;
    data_full = 1'b0;
    wait_io(1, NW, ok);
    g_b = (blk_q.size() > 0) ? blk_q.pop_front() : 'x;
    e_b = exp_blk_q.pop_front();
    chk_cnt++; if (g_b !== e_b) $display("FAIL full_block: got %h exp %h", g_b, e_b); else pass_cnt++;
    for (int i = 0; i < NW; i++) begin
      g_w = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      e_w = exp_q.pop_front();
      chk_cnt++; if (g_w !== e_w) $display("FAIL full_word%0d: got %h exp %h", i, g_w, e_w); else pass_cnt++;
    end
    wait_idle(ok);
    repeat (5) @(negedge clock);
    chk_cnt++; if (got_q.size() != 0) $display("FAIL full_no_duplicate: got %0d extra words exp 0", got_q.size()); else pass_cnt++;
    chk_cnt++; if (blocks_out !== CW'(exp_blocks)) $display("FAIL full_blocks_out: got %0d exp %0d", blocks_out, exp_blocks); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    logic [BW-1:0] blk, g_b, e_b;
    logic [DW-1:0] g_w, e_w;
    bit ok;
    blk = rand_block();
    push_words(blk, 0, NW);
    expect_block(blk);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clock); #1;
      if (got_q.size() >= 1) begin ok = 1'b1; break; end
    end
    chk_cnt++; if (!ok) $display("FAIL rstmid_first_write_timeout: got 0 exp 1"); else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk_cnt++; if ({data_rd, data_wr, core_in_valid, core_out_ready} !== 4'b0) $display("FAIL rstmid_strobes: got %b exp 0000", {data_rd, data_wr, core_in_valid, core_out_ready}); else pass_cnt++;
    chk_cnt++; if (data_dout !== '0 || core_in_data !== '0) $display("FAIL rstmid_data: got %h/%h exp 0/0", data_dout, core_in_data); else pass_cnt++;
    chk_cnt++; if ({blocks_in, blocks_out} !== '0 || busy !== 1'b0) $display("FAIL rstmid_counters: got %0d/%0d busy %b exp 0/0/0", blocks_in, blocks_out, busy); else pass_cnt++;
    g_w = (got_q.size() > 0) ? got_q.pop_front() : 'x;
    e_w = exp_q.pop_front();
    chk_cnt++; if (g_w !== e_w) $display("FAIL rstmid_first_word: got %h exp %h", g_w, e_w); else pass_cnt++;
    void'(blk_q.pop_front());
    void'(exp_blk_q.pop_front());
    exp_q.delete();
    exp_blocks = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    blk = rand_block();
    push_words(blk, 0, NW);
    expect_block(blk);
    wait_io(1, NW, ok);
    chk_cnt++; if (!ok || got_q.size() != NW) $display("FAIL rstmid_fresh_count: got %0d words exp %0d", got_q.size(), NW); else pass_cnt++;
    g_b = (blk_q.size() > 0) ? blk_q.pop_front() : 'x;
    e_b = exp_blk_q.pop_front();
    chk_cnt++; if (g_b !== e_b) $display("FAIL rstmid_block: got %h exp %h", g_b, e_b); else pass_cnt++;
    for (int i = 0; i < NW; i++) begin
      g_w = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      e_w = exp_q.pop_front();
      chk_cnt++; if (g_w !== e_w) $display("FAIL rstmid_word%0d: got %h exp %h", i, g_w, e_w); else pass_cnt++;
    end
    wait_idle(ok);
    chk_cnt++; if (blocks_in !== 16'd1 || blocks_out !== 16'd1) $display("FAIL rstmid_counters_after: got %0d/%0d exp 1/1", blocks_in, blocks_out); else pass_cnt++;
  endtask

  task automatic test_byte_order();
    logic [BW-1:0] blk, g_b;
    logic [DW-1:0] g_w, e_top;
    bit ok;
`ifdef AES_BRIDGE_BYTE_SWAP_EN
    e_top = 32'h44332211;
`else
    e_top = 32'h11223344;
`endif
    blk = {32'h11223344, $urandom(), $urandom(), $urandom()};
    push_words(blk, 0, NW);
    expect_block(blk);
    wait_io(1, NW, ok);
    g_b = (blk_q.size() > 0) ? blk_q.pop_front() : 'x;
    void'(exp_blk_q.pop_front());
    chk_cnt++; if (g_b[127:96] !== e_top) $display("FAIL order_block_top: got %h exp %h", g_b[127:96], e_top); else pass_cnt++;
    for (int i = 0; i < NW; i++) begin
      g_w = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      e_top = exp_q.pop_front();
      chk_cnt++; if (g_w !== e_top) $display("FAIL order_word%0d: got %h exp %h", i, g_w, e_top); else pass_cnt++;
    end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] b0, b1, g_b, e_b;
    logic [DW-1:0] g_w, e_w;
    int rd0;
    bit ok;
    b0 = rand_block();
    b1 = rand_block();
    rd0 = rd_pulses;
    push_words(b0, 0, NW);
    push_words(b1, 0, NW);
    expect_block(b0);
    expect_block(b1);
    wait_io(2, 2 * NW, ok);
    chk_cnt++; if (!ok) $display("FAIL b2b_timeout: got %0d blocks %0d words exp 2/8", blk_q.size(), got_q.size()); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      g_b = (blk_q.size() > 0) ? blk_q.pop_front() : 'x;
      e_b = exp_blk_q.pop_front();
      chk_cnt++; if (g_b !== e_b) $display("FAIL b2b_block%0d: got %h exp %h", k, g_b, e_b); else pass_cnt++;
    end
    for (int i = 0; i < 2 * NW; i++) begin
      g_w = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      e_w = exp_q.pop_front();
      chk_cnt++; if (g_w !== e_w) $display("FAIL b2b_word%0d: got %h exp %h", i, g_w, e_w); else pass_cnt++;
    end
    wait_idle(ok);
    chk_cnt++; if (rd_pulses - rd0 != 2 * NW) $display("FAIL b2b_rd_pulses: got %0d exp %0d", rd_pulses - rd0, 2 * NW); else pass_cnt++;
    chk_cnt++; if (blocks_in !== CW'(exp_blocks) || blocks_out !== CW'(exp_blocks)) $display("FAIL b2b_counters: got %0d/%0d exp %0d", blocks_in, blocks_out, exp_blocks); else pass_cnt++;
    chk_cnt++; if (overlap_cnt != 0) $display("FAIL rd_wr_overlap: got %0d cycles exp 0", overlap_cnt); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_block();
    test_partial_block();
    test_in_backpressure();
    test_out_backpressure();
    test_reset_mid_drain();
    test_byte_order();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
